// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding, bus widths, the address legality check
// and the per-byte parity helper used when SECURE_PARITY_EN is defined.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // A word address is legal when it is word aligned and inside the array.
    function automatic logic addrIsValid(input logic [31:0] addr, input int depthLog2);
        return (addr[1:0] == 2'b00) && ((addr >> (depthLog2 + 2)) == 32'd0);
    endfunction

    // Even parity of each byte: bit i is the XOR of byte i.
    function automatic logic [BE_W-1:0] byteParity(input logic [DATA_W-1:0] word);
        logic [BE_W-1:0] par;
        for (int i = 0; i < BE_W; i++) begin
            par[i] = ^word[8*i +: 8];
        end
        return par;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channels between the processor's
// data-memory port (master) and the responder (slave).
// parity_inject exists only when SECURE_PARITY_EN is defined.
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
`ifdef SECURE_PARITY_EN
    logic        parity_inject;
`endif
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
`ifdef SECURE_PARITY_EN
        output parity_inject,
`endif
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
`ifdef SECURE_PARITY_EN
        input  parity_inject,
`endif
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/data_mem_responder_array.sv
// Word-organised data RAM with byte-enable writes and a registered read port.
// With SECURE_PARITY_EN defined, one even-parity bit is kept per byte and a
// read reports whether any stored parity disagrees with the stored data.
// Contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [BE_W-1:0]       i_be,
`ifdef SECURE_PARITY_EN
    input  logic                  i_parityInject,
    output logic                  o_parityErr,
`endif
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Byte-masked write and registered word read.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

`ifdef SECURE_PARITY_EN
    logic [BE_W-1:0] r_par [DEPTH];
    logic [BE_W-1:0] w_wrPar;
    logic            r_parErr;

    // Injection flips byte 0's parity so a later load of that word flags an error.
    assign w_wrPar = byteParity(i_wdata) ^ {{(BE_W-1){1'b0}}, i_parityInject};

    // Parity bits follow their bytes; reads recompute and compare.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (i_be[i]) begin
                    r_par[i_addr][i] <= w_wrPar[i];
                end
            end
        end
        if (i_re) begin
            r_parErr <= |(byteParity(r_mem[i_addr]) ^ r_par[i_addr]);
        end
    end

    assign o_parityErr = r_parErr;
`endif

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the processor load/store port. One request at a time:
// IDLE accepts, WAIT burns WAIT_CYCLES wait states, the array access happens
// on the edge entering RESP, and RESP holds the response until it is taken.
// Optional feature macro: SECURE_PARITY_EN (per-byte parity with injection).
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    // Counter is loaded with one less than the wait count; leaving WAIT happens at zero.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            r_state;
    state_t            w_nextState;
    logic [3:0]        r_waitCnt;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;
    logic              r_addrErr;
    logic              r_inject;

    logic              w_reqReady;
    logic              w_accept;
    logic              w_reqAddrErr;
    logic              w_reqInject;
    logic              w_access;
    logic              w_doAccess;
    logic              w_accWe;
    logic [31:0]       w_accAddr;
    logic [DATA_W-1:0] w_accWdata;
    logic [BE_W-1:0]   w_accBe;
    logic              w_accErr;
    logic              w_accInject;
    logic [DATA_W-1:0] w_arrRdata;
    logic              w_parityErr;

    assign w_reqReady   = (r_state == IDLE) && !reset;
    assign w_accept     = bus.req_valid && w_reqReady;
    assign w_reqAddrErr = !addrIsValid(bus.req_addr, DEPTH_LOG2);

`ifdef SECURE_PARITY_EN
    assign w_reqInject = bus.parity_inject;
`else
    assign w_reqInject = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state, plus the strobe marking the edge that enters RESP.
    always_comb begin
        w_nextState = r_state;
        w_access    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_nextState = RESP;
                        w_access    = 1'b1;
                    end else begin
                        w_nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_waitCnt == 4'd0) begin
                    w_nextState = RESP;
                    w_access    = 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // A reset on the access edge drops the pending store.
    assign w_doAccess = w_access && !reset;

    // Request latch and wait-state down-counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_waitCnt <= 4'd0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_addrErr <= 1'b0;
            r_inject  <= 1'b0;
        end else if (w_accept) begin
            r_waitCnt <= WAIT_LOAD;
            r_we      <= bus.req_we;
            r_addr    <= bus.req_addr;
            r_wdata   <= bus.req_wdata;
            r_be      <= bus.req_be;
            r_addrErr <= w_reqAddrErr;
            r_inject  <= w_reqInject;
        end else if ((r_state == WAIT) && (r_waitCnt != 4'd0)) begin
            r_waitCnt <= r_waitCnt - 4'd1;
        end
    end

    // With zero wait states the access coincides with acceptance, so use the live request.
    assign w_accWe     = (r_state == IDLE) ? bus.req_we    : r_we;
    assign w_accAddr   = (r_state == IDLE) ? bus.req_addr  : r_addr;
    assign w_accWdata  = (r_state == IDLE) ? bus.req_wdata : r_wdata;
    assign w_accBe     = (r_state == IDLE) ? bus.req_be    : r_be;
    assign w_accErr    = (r_state == IDLE) ? w_reqAddrErr  : r_addrErr;
    assign w_accInject = (r_state == IDLE) ? w_reqInject   : r_inject;

    dmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk            (clk),
        .i_we           (w_doAccess && w_accWe && !w_accErr),
        .i_re           (w_doAccess && !w_accWe && !w_accErr),
        .i_addr         (w_accAddr[DEPTH_LOG2+1:2]),
        .i_wdata        (w_accWdata),
        .i_be           (w_accBe),
`ifdef SECURE_PARITY_EN
        .i_parityInject (w_accInject),
        .o_parityErr    (w_parityErr),
`endif
        .o_rdata        (w_arrRdata)
    );

`ifndef SECURE_PARITY_EN
    assign w_parityErr = 1'b0;
`endif

    assign bus.req_ready  = w_reqReady;
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_rdata = ((r_state == RESP) && !r_we && !r_addrErr) ? w_arrRdata : '0;
    assign bus.resp_err   = (r_state == RESP) && (r_addrErr || (!r_we && w_parityErr));

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios followed by
// randomized loads/stores compared against a word-array reference model.
// Define SECURE_PARITY_EN to also exercise parity injection.
module tb_data_mem_responder;

    localparam int DEPTH_LOG2  = 10;
    localparam int WAIT_CYCLES = 2;
    localparam int DEPTH       = 2 ** DEPTH_LOG2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [31:0] modelMem [DEPTH];
    bit          modelBad [DEPTH];

    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH_LOG2  (DEPTH_LOG2),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Random request-side noise that the responder must ignore while busy.
    task automatic driveJunk(input bit withResp);
        bus.req_valid = 1'($urandom);
        bus.req_we    = 1'($urandom);
        bus.req_addr  = 32'($urandom_range(0, 15)) << 2;
        bus.req_wdata = $urandom;
        bus.req_be    = 4'($urandom);
`ifdef SECURE_PARITY_EN
        bus.parity_inject = 1'($urandom);
`endif
        if (withResp) bus.resp_ready = 1'($urandom);
    endtask

    // One complete transaction: predict, issue, time, check hold and release, update model.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input logic inject, input int hold,
                                 input string tag);
        logic        ok;
        int          idx;
        logic [31:0] expRdata;
        logic        expErr;
        int          lat;
        bit          seen;
        int          w;

        ok  = (addr[1:0] == 2'b00) && ((addr >> 2) < 32'(DEPTH));
        idx = ok ? int'(addr >> 2) : 0;
        if (!ok) begin
            expErr   = 1'b1;
            expRdata = 32'd0;
        end else if (we) begin
            expErr   = 1'b0;
            expRdata = 32'd0;
        end else begin
            expErr   = modelBad[idx];
            expRdata = modelMem[idx];
        end

        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_be     = be;
`ifdef SECURE_PARITY_EN
        bus.parity_inject = inject;
`endif
        bus.resp_ready = 1'b0;
        w = 0;
        while (bus.req_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checkOutput({tag, "_reqReady"}, 32'(bus.req_ready), 32'd1);
        if (bus.req_ready !== 1'b1) begin
            bus.req_valid = 1'b0;
            return;
        end

        @(posedge clk);
        #1;
        driveJunk(1'b1);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid === 1'b1) seen = 1'b1;
            else driveJunk(1'b1);
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(WAIT_CYCLES + 1));
        if (!seen) begin
            bus.req_valid  = 1'b0;
            bus.resp_ready = 1'b0;
            return;
        end
        checkOutput({tag, "_rdata"}, bus.resp_rdata, expRdata);
        checkOutput({tag, "_err"}, 32'(bus.resp_err), 32'(expErr));
        bus.resp_ready = (hold == 0);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput({tag, "_holdValid"}, 32'(bus.resp_valid), 32'd1);
            checkOutput({tag, "_holdRdata"}, bus.resp_rdata, expRdata);
            checkOutput({tag, "_holdErr"}, 32'(bus.resp_err), 32'(expErr));
            checkOutput({tag, "_holdReqReady"}, 32'(bus.req_ready), 32'd0);
            driveJunk(1'b0);
            if (h == hold - 1) bus.resp_ready = 1'b1;
        end

        @(negedge clk);
        checkOutput({tag, "_doneValid"}, 32'(bus.resp_valid), 32'd0);
        checkOutput({tag, "_doneReqReady"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;

        if (ok && we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) modelMem[idx][8*i +: 8] = wdata[8*i +: 8];
            end
            if (be[0]) modelBad[idx] = inject;
        end
    endtask

    // Guard against a hung design.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios, then randomized traffic.
    initial begin
        logic [31:0] a;
        logic        inj;
        int          sel;

        for (int i = 0; i < DEPTH; i++) begin
            modelMem[i] = 32'd0;
            modelBad[i] = 1'b0;
        end
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.req_be     = 4'd0;
`ifdef SECURE_PARITY_EN
        bus.parity_inject = 1'b0;
`endif
        bus.resp_ready = 1'b0;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_respValid", 32'(bus.resp_valid), 32'd0);
        checkOutput("rst_reqReady", 32'(bus.req_ready), 32'd0);
        checkOutput("rst_rdata", bus.resp_rdata, 32'd0);
        checkOutput("rst_err", 32'(bus.resp_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("postRst_reqReady", 32'(bus.req_ready), 32'd1);
        checkOutput("postRst_respValid", 32'(bus.resp_valid), 32'd0);

        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 0, "t1_store");
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 0, "t1_load");
        applyStimulus(1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0, 0, "t2_store");
        applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 1, "t2_load");

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'(i) << 2, $urandom, 4'hF, 1'b0, 0, "init");
        end

        applyStimulus(1'b0, 32'h13, 32'h0, 4'hF, 1'b0, 0, "t3_misaligned");
        applyStimulus(1'b0, 32'h1000, 32'h0, 4'hF, 1'b0, 0, "t3_range");
        applyStimulus(1'b1, 32'h1000, 32'hA5A5A5A5, 4'hF, 1'b0, 0, "t3_storeRange");
        applyStimulus(1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 0, "t3_word0");
        applyStimulus(1'b1, 32'h14, 32'hFFFFFFFF, 4'h0, 1'b0, 0, "t3_beZero");
        applyStimulus(1'b0, 32'h14, 32'h0, 4'h0, 1'b0, 0, "t3_beZeroLoad");

        applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 5, "t4_hold");

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hCAFEF00D;
        bus.req_be    = 4'hF;
        checkOutput("t5_reqReady", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        checkOutput("t5_inWait", 32'(bus.resp_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t5_rstValid", 32'(bus.resp_valid), 32'd0);
        checkOutput("t5_rstReqReady", 32'(bus.req_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t5_afterReqReady", 32'(bus.req_ready), 32'd1);
        repeat (4) @(negedge clk);
        checkOutput("t5_quietValid", 32'(bus.resp_valid), 32'd0);
        applyStimulus(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 0, "t5_load");

`ifdef SECURE_PARITY_EN
        applyStimulus(1'b1, 32'h30, 32'h000000FF, 4'hF, 1'b1, 0, "t6_injStore");
        applyStimulus(1'b0, 32'h30, 32'h0, 4'hF, 1'b0, 0, "t6_badLoad");
        applyStimulus(1'b1, 32'h30, 32'h000000FF, 4'hF, 1'b0, 0, "t6_cleanStore");
        applyStimulus(1'b0, 32'h30, 32'h0, 4'hF, 1'b0, 0, "t6_goodLoad");
`endif

        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 6)      a = 32'($urandom_range(0, 15)) << 2;
            else if (sel == 7) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            else if (sel == 8) a = 32'($urandom_range(DEPTH, 2 * DEPTH - 1)) << 2;
            else               a = $urandom | 32'h80000000;
`ifdef SECURE_PARITY_EN
            inj = ($urandom_range(0, 3) == 0);
`else
            inj = 1'b0;
`endif
            applyStimulus(1'($urandom), a, $urandom, 4'($urandom), inj,
                          $urandom_range(0, 3), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
